// File: rtl/tbuf_arb_pkg.sv
// Shared state encoding and width helpers for the tri-state bus arbiter.
package tbuf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2,
        PARK  = 2'd3
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after the pointer, wrapping.
module rr_pick
    import tbuf_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        i_req,
    input  logic [clog2(NREQ)-1:0] i_ptr,
    output logic [clog2(NREQ)-1:0] o_idx,
    output logic                   o_valid
);

    localparam int IW = clog2(NREQ);

    int w_cand;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!o_valid && i_req[w_cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner sequencer for a shared OBUFT tri-state bus with high-Z turnaround between owners.
// Optional macro TBUF_PARK_EN: an owner that drops REQ parks on the bus (T=0) instead of releasing it.
module tbuf_bus_arbiter
    import tbuf_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int W         = 8,
    parameter int TA_CYC    = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*W-1:0]      DIN,
    output logic [NREQ-1:0]        GNT,
    output logic [W-1:0]           O,
    output logic                   T,
    output logic [clog2(NREQ)-1:0] OWNER,
    output logic                   BUSY
);

    localparam int IW = clog2(NREQ);
    localparam int BW = clog2(MAX_BURST + 1);
    localparam int CW = clog2(TA_CYC + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] TURN_LAST  = CW'(TA_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

    arb_state_e r_state, w_nextState;
    logic [IW-1:0] r_owner, w_nextOwner;
    logic [IW-1:0] r_ptr, w_nextPtr;
    logic [BW-1:0] r_burst, w_nextBurst;
    logic [CW-1:0] r_turn, w_nextTurn;
    logic [W-1:0]  r_o, w_nextO;
    logic          r_t, w_nextT;

    logic [NREQ-1:0] w_ownerMask;
    logic [NREQ-1:0] w_others;
    logic            w_xfer;
    logic [IW-1:0]   w_winIdx;
    logic            w_winValid;
    logic [IW-1:0]   w_afterWin;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (REQ),
        .i_ptr   (r_ptr),
        .o_idx   (w_winIdx),
        .o_valid (w_winValid)
    );

    assign w_ownerMask = NREQ'(1) << r_owner;
    assign w_others    = REQ & ~w_ownerMask;
    assign w_xfer      = (r_state == DRIVE) && REQ[r_owner];
    assign w_afterWin  = (w_winIdx == LAST_IDX) ? '0 : w_winIdx + 1'b1;

    // T defaults to high-Z; only a transfer (or a parked owner) keeps the bus driven.
    always_comb begin
        w_nextState = r_state;
        w_nextOwner = r_owner;
        w_nextPtr   = r_ptr;
        w_nextBurst = r_burst;
        w_nextTurn  = r_turn;
        w_nextO     = r_o;
        w_nextT     = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_winValid) begin
                    w_nextState = DRIVE;
                    w_nextOwner = w_winIdx;
                    w_nextPtr   = w_afterWin;
                    w_nextBurst = '0;
                end
            end
            DRIVE: begin
                if (w_xfer) begin
                    w_nextO = DIN[int'(r_owner)*W +: W];
                    w_nextT = 1'b0;
                    if (r_burst == BURST_LAST) begin
                        w_nextBurst = '0;
                        if (|w_others) begin
                            w_nextState = TURN;
                            w_nextTurn  = '0;
                        end
                    end else begin
                        w_nextBurst = r_burst + 1'b1;
                    end
                end else begin
                    w_nextBurst = '0;
`ifdef TBUF_PARK_EN
                    w_nextState = PARK;
                    w_nextT     = r_t;
`else
                    w_nextState = TURN;
                    w_nextTurn  = '0;
`endif
                end
            end
            TURN: begin
                if (r_turn == TURN_LAST) begin
                    if (w_winValid) begin
                        w_nextState = DRIVE;
                        w_nextOwner = w_winIdx;
                        w_nextPtr   = w_afterWin;
                        w_nextBurst = '0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextTurn = r_turn + 1'b1;
                end
            end
            PARK: begin
`ifdef TBUF_PARK_EN
                // Parked owner re-wins without a gap; anyone else must go through turnaround.
                if (REQ[r_owner]) begin
                    w_nextState = DRIVE;
                    w_nextT     = r_t;
                end else if (|w_others) begin
                    w_nextState = TURN;
                    w_nextTurn  = '0;
                end else begin
                    w_nextT = r_t;
                end
`else
                w_nextState = IDLE;
`endif
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
            r_turn  <= '0;
            r_o     <= '0;
            r_t     <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
            r_ptr   <= w_nextPtr;
            r_burst <= w_nextBurst;
            r_turn  <= w_nextTurn;
            r_o     <= w_nextO;
            r_t     <= w_nextT;
        end
    end

    assign GNT   = w_xfer ? w_ownerMask : '0;
    assign O     = r_o;
    assign T     = r_t;
    assign OWNER = r_owner;
    assign BUSY  = (r_state != IDLE);

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Bench for tbuf_bus_arbiter: vector table, directed multi-cycle sequences, randomized traffic vs a reference model.
module tb_tbuf_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int W         = 8;
    localparam int TA_CYC    = 2;
    localparam int MAX_BURST = 8;
    localparam logic [NREQ*W-1:0] TBL_DIN = 32'h11223CA5;

    typedef struct {
        bit              rst;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
        logic [W-1:0]    o;
        logic            t;
        logic            busy;
        logic [1:0]      owner;
    } vec_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   REQ = '0;
    logic [NREQ*W-1:0] DIN = '0;
    logic [NREQ-1:0]   GNT;
    logic [W-1:0]      O;
    logic              T;
    logic [1:0]        OWNER;
    logic              BUSY;

    tbuf_bus_arbiter #(
        .NREQ(NREQ), .W(W), .TA_CYC(TA_CYC), .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN),
        .GNT(GNT), .O(O), .T(T), .OWNER(OWNER), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model: who owns the bus, how long the cooldown lasts, and what the pads show.
    int   mOwner, mPtr, mCount, mCool;
    bit   mActive, mParked;
    logic [W-1:0] mO;
    logic mT;

    logic [NREQ-1:0] sGnt;
    logic [W-1:0]    sO;
    logic            sT;
    logic [1:0]      sOwner;
    logic            sBusy;

    int prevGnt = -1;
    int lastWordOwner = -1;
    int tRun = 0;

    vec_t tbl[17];
    int   gIdx[64];
    logic tObs[64];
    logic [W-1:0] oObs[64];
    int   rIdx[$];
    int   rStart[$];
    int   rEnd[$];
    logic [NREQ-1:0] rq = '0;
    int   cnt;
    int   firstG1;
    int   expFirstG1;
    int   tWin;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int gntIndex(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    function automatic int pickRR(input logic [NREQ-1:0] req, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = 0; mPtr = 0; mCount = 0; mCool = 0;
        mActive = 0; mParked = 0; mO = '0; mT = 1'b1;
    endtask

    task automatic grantTo(input int w);
        mActive = 1; mOwner = w; mPtr = (w + 1) % NREQ; mCount = 0;
    endtask

    task automatic modelAdvance(input bit rst, input logic [NREQ-1:0] req, input logic [NREQ*W-1:0] din);
        logic [NREQ-1:0] others;
        int w;
        if (rst) begin
            modelReset();
            return;
        end
        others = req & ~(NREQ'(1) << mOwner);
        if (mActive) begin
            if (req[mOwner]) begin
                mO = din[mOwner*W +: W];
                mT = 1'b0;
                mCount++;
                if (mCount == MAX_BURST) begin
                    mCount = 0;
                    if (others != '0) begin
                        mActive = 0;
                        mCool = TA_CYC;
                    end
                end
            end else begin
                mCount = 0;
                mActive = 0;
`ifdef TBUF_PARK_EN
                mParked = 1;
`else
                mCool = TA_CYC;
                mT = 1'b1;
`endif
            end
        end else if (mCool > 0) begin
            mT = 1'b1;
            mCool--;
            if (mCool == 0) begin
                w = pickRR(req, mPtr);
                if (w >= 0) grantTo(w);
            end
        end else if (mParked) begin
            if (req[mOwner]) begin
                mParked = 0;
                mActive = 1;
            end else if (others != '0) begin
                mParked = 0;
                mCool = TA_CYC;
                mT = 1'b1;
            end
        end else begin
            mT = 1'b1;
            w = pickRR(req, mPtr);
            if (w >= 0) grantTo(w);
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [NREQ-1:0] req, input logic [NREQ*W-1:0] din, input bit useModel);
        logic [NREQ-1:0] expGnt;
        @(posedge CLK);
        #1;
        RST = rst;
        REQ = req;
        DIN = din;
        @(negedge CLK);
        sGnt = GNT; sO = O; sT = T; sOwner = OWNER; sBusy = BUSY;
        expGnt = (mActive && req[mOwner]) ? (NREQ'(1) << mOwner) : '0;
        if (useModel) begin
            checkOutput("model.gnt", 32'(sGnt), 32'(expGnt));
            checkOutput("model.o", 32'(sO), 32'(mO));
            checkOutput("model.t", 32'(sT), 32'(mT));
            checkOutput("model.owner", 32'(sOwner), 32'(mOwner));
            checkOutput("model.busy", 32'(sBusy), 32'(mActive || mParked || (mCool > 0)));
        end
        checkOutput("onehot", 32'($countones(sGnt) <= 1), 32'd1);
        if (prevGnt >= 0) begin
            if (lastWordOwner >= 0 && prevGnt != lastWordOwner) begin
                checkOutput("ownerGap", 32'(tRun >= TA_CYC), 32'd1);
            end
            lastWordOwner = prevGnt;
            tRun = 0;
        end else if (sT) begin
            tRun++;
        end else begin
            tRun = 0;
        end
        prevGnt = rst ? -1 : gntIndex(sGnt);
        if (rst) lastWordOwner = -1;
        modelAdvance(rst, req, din);
    endtask

    task automatic buildRuns(input int len);
        rIdx.delete(); rStart.delete(); rEnd.delete();
        for (int c = 0; c < len; c++) begin
            if (gIdx[c] >= 0) begin
                if (rIdx.size() > 0 && rIdx[rIdx.size()-1] == gIdx[c] && rEnd[rEnd.size()-1] == c - 1) begin
                    rEnd[rEnd.size()-1] = c;
                end else begin
                    rIdx.push_back(gIdx[c]);
                    rStart.push_back(c);
                    rEnd.push_back(c);
                end
            end
        end
    endtask

    task automatic recordCycle(input int c, input bit rst, input logic [NREQ-1:0] req, input logic [NREQ*W-1:0] din);
        applyStimulus(rst, req, din, 1'b1);
        gIdx[c] = gntIndex(sGnt);
        tObs[c] = sT;
        oObs[c] = sO;
    endtask

    initial begin
        //              rst   req      gnt      o      t     busy  owner
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 8'h00, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 8'h00, 1'b1, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b1, 2'd0};
        tbl[4]  = '{1'b0, 4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1, 2'd0};
`ifdef TBUF_PARK_EN
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1, 2'd0};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b1, 2'd0};
`else
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0, 2'd0};
`endif
        tbl[10] = '{1'b0, 4'b1000, 4'b0000, 8'h00, 1'b1, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 4'b1000, 4'b1000, 8'h00, 1'b1, 1'b1, 2'd3};
        tbl[12] = '{1'b0, 4'b1000, 4'b1000, 8'h11, 1'b0, 1'b1, 2'd3};
        tbl[13] = '{1'b1, 4'b1000, 4'b1000, 8'h11, 1'b0, 1'b1, 2'd3};
        tbl[14] = '{1'b0, 4'b1000, 4'b0000, 8'h00, 1'b1, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 4'b1000, 4'b1000, 8'h00, 1'b1, 1'b1, 2'd3};
        tbl[16] = '{1'b0, 4'b0000, 4'b0000, 8'h11, 1'b0, 1'b1, 2'd3};

        repeat (2) @(posedge CLK);
        modelReset();

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].req, TBL_DIN, 1'b0);
            checkOutput($sformatf("tbl%0d.gnt", i), 32'(sGnt), 32'(tbl[i].gnt));
            checkOutput($sformatf("tbl%0d.o", i), 32'(sO), 32'(tbl[i].o));
            checkOutput($sformatf("tbl%0d.t", i), 32'(sT), 32'(tbl[i].t));
            checkOutput($sformatf("tbl%0d.busy", i), 32'(sBusy), 32'(tbl[i].busy));
            checkOutput($sformatf("tbl%0d.owner", i), 32'(sOwner), 32'(tbl[i].owner));
        end

        // Two steady requesters: burst of MAX_BURST, TA_CYC gap, then round-robin back to 0.
        applyStimulus(1'b1, '0, '0, 1'b1);
        for (int c = 0; c < 40; c++) recordCycle(c, 1'b0, 4'b0011, NREQ*W'($urandom()));
        buildRuns(40);
        checkOutput("burst.runCount", 32'(rIdx.size() >= 3), 32'd1);
        if (rIdx.size() >= 3) begin
            checkOutput("burst.run0Idx", 32'(rIdx[0]), 32'd0);
            checkOutput("burst.run0Len", 32'(rEnd[0] - rStart[0] + 1), 32'(MAX_BURST));
            checkOutput("burst.run1Idx", 32'(rIdx[1]), 32'd1);
            checkOutput("burst.run1Len", 32'(rEnd[1] - rStart[1] + 1), 32'(MAX_BURST));
            checkOutput("burst.run2Idx", 32'(rIdx[2]), 32'd0);
            checkOutput("burst.gntGap", 32'(rStart[1] - rEnd[0] - 1), 32'(TA_CYC));
            cnt = 0;
            for (int c = rEnd[0] + 2; c <= rStart[1]; c++) if (tObs[c]) cnt++;
            checkOutput("burst.tHighGap", 32'(cnt), 32'(TA_CYC));
        end

        // Lone requester streams across burst boundaries without a gap.
        applyStimulus(1'b1, '0, '0, 1'b1);
        for (int c = 0; c < 20; c++) recordCycle(c, 1'b0, 4'b0001, NREQ*W'($urandom()));
        cnt = 0;
        for (int c = 1; c < 20; c++) if (gIdx[c] == 0) cnt++;
        checkOutput("solo.grants", 32'(cnt), 32'd19);
        cnt = 0;
        for (int c = 2; c < 20; c++) if (tObs[c]) cnt++;
        checkOutput("solo.tHigh", 32'(cnt), 32'd0);

        // Owner 2 drops and returns, then owner 1 takes over.
        applyStimulus(1'b1, '0, '0, 1'b1);
        for (int c = 0; c < 17; c++) begin
            if (c < 4 || c == 7 || c == 8) rq = 4'b0100;
            else if (c >= 10)              rq = 4'b0010;
            else                           rq = 4'b0000;
            recordCycle(c, 1'b0, rq, TBL_DIN);
        end
        checkOutput("own2.returnGnt", 32'(gIdx[8]), 32'd2);
        checkOutput("own2.oHold", 32'(oObs[6]), 32'h22);
        firstG1 = -1;
        for (int c = 16; c >= 0; c--) if (gIdx[c] == 1) firstG1 = c;
`ifdef TBUF_PARK_EN
        expFirstG1 = 13;
        tWin = 11;
        cnt = 0;
        for (int c = 4; c <= 10; c++) if (tObs[c]) cnt++;
        checkOutput("park.tLow", 32'(cnt), 32'd0);
`else
        expFirstG1 = 12;
        tWin = 10;
        cnt = 0;
        for (int c = 5; c <= 8; c++) if (tObs[c]) cnt++;
        checkOutput("drop.tHigh", 32'(cnt), 32'd4);
`endif
        checkOutput("own1.firstGnt", 32'(firstG1), 32'(expFirstG1));
        cnt = 0;
        for (int c = tWin; c < tWin + TA_CYC + 1; c++) if (tObs[c]) cnt++;
        checkOutput("own1.tHighGap", 32'(cnt), 32'(TA_CYC + 1));

        rq = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(5) == 0) rq[b] = ~rq[b];
            end
            applyStimulus($urandom_range(499) == 0, rq, NREQ*W'($urandom()), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
